// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Sleep / clock-gating sequencer for the core clock gate: qualified-idle holdoff,
// glitch-free registered gate enable, wake latency with ack pulse, gated-cycle counter.
module cv32e40p_clock_gate_ctrl #(
   parameter int unsigned HOLDOFF  = 4,
   parameter int unsigned WAKE_LAT = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sleep_req_i,
   input  logic             busy_i,
   input  logic             wake_i,
   input  logic             force_en_i,
   input  logic             cnt_clr_i,
   output logic             clock_en_o,
   output logic             sleeping_o,
   output logic             wake_ack_o,
   output logic [CNT_W-1:0] gated_cnt_o
);

   localparam int unsigned MAX_LAT = (HOLDOFF > WAKE_LAT) ? HOLDOFF : WAKE_LAT;
   localparam int unsigned CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HOLDOFF,
      ST_GATED,
      ST_WAKE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            idle;
   logic            wake_req;

   assign idle     = sleep_req_i & ~busy_i & ~wake_i & ~force_en_i;
   assign wake_req = wake_i | force_en_i;

   // Outputs default to "clock running" every edge; only a branch that lands in
   // GATED overrides them, so the gate enable is a pure flop of the next state.
   // NOTE: all state here is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_RUN;
         cnt        <= '0;
         clock_en_o <= 1'b1;
         sleeping_o <= 1'b0;
         wake_ack_o <= 1'b0;
      end else begin
         clock_en_o <= 1'b1;
         sleeping_o <= 1'b0;
         wake_ack_o <= 1'b0;
         case (state)
            ST_RUN: begin
               if (idle) begin
                  state <= ST_HOLDOFF;
                  cnt   <= CW'(HOLDOFF - 1);
               end
            end
            ST_HOLDOFF: begin
               if (!idle) begin
                  state <= ST_RUN;
               end else if (cnt == '0) begin
                  state      <= ST_GATED;
                  clock_en_o <= 1'b0;
                  sleeping_o <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_GATED: begin
               // sleep_req/busy come from the stopped core domain and are ignored here
               if (wake_req) begin
                  state <= ST_WAKE;
                  cnt   <= CW'(WAKE_LAT - 1);
               end else begin
                  clock_en_o <= 1'b0;
                  sleeping_o <= 1'b1;
               end
            end
            ST_WAKE: begin
               if (cnt == '0) begin
                  state      <= ST_RUN;
                  wake_ack_o <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= ST_RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Clear wins over increment; the count sticks at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gated_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         gated_cnt_o <= '0;
      end else if (state == ST_GATED && !(&gated_cnt_o)) begin
         gated_cnt_o <= gated_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: doc/cv32e40p_clock_gate_ctrl.md
# cv32e40p_clock_gate_ctrl

Sleep/clock-gating controller that sequences the core clock gate. It runs on the free-running clock and decides when the gated core clock may stop: only after a qualified sleep request has held for a programmable holdoff. It restarts the clock on a wake event and signals the core when the wake latency has elapsed. `clock_en_o` drives the clock gate's `en_i` input directly, and the block also keeps a saturating count of gated cycles for performance monitoring.

## Interface
Parameters:
- `HOLDOFF`, default 4: consecutive qualified-idle cycles before gating. Legal range ≥1.
- `WAKE_LAT`, default 2: cycles the clock runs after ungating before `wake_ack_o`. Legal range ≥1.
- `CNT_W`, default 32: width of the gated-cycle counter.

Ports:
- `clk_i` in 1: free-running (ungated) clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `sleep_req_i` in 1: core requests sleep (WFI retired, pipeline drained). Level.
- `busy_i` in 1: outstanding bus/LSU activity. Blocks gating.
- `wake_i` in 1: wake event (pending enabled IRQ or debug request). Level.
- `force_en_i` in 1: test/debug override that keeps the clock running.
- `cnt_clr_i` in 1: synchronous clear of `gated_cnt_o`.
- `clock_en_o` out 1: enable to the clock gate.
- `sleeping_o` out 1: high while the clock is gated.
- `wake_ack_o` out 1: one-cycle pulse when the core clock is stable again.
- `gated_cnt_o` out `CNT_W`: saturating count of cycles spent in GATED.

## Operation
- Qualified-idle condition: `idle = sleep_req_i & ~busy_i & ~wake_i & ~force_en_i`.
- States: RUN, HOLDOFF, GATED, WAKE. Down-counter `cnt` has width `$clog2(max(HOLDOFF,WAKE_LAT)+1)`.
- RUN:
  - If `idle`, go to HOLDOFF and load `cnt = HOLDOFF-1`.
  - Otherwise stay in RUN.
- HOLDOFF:
  - If `~idle`, go to RUN. Abort has priority over completion.
  - Else if `cnt == 0`, go to GATED.
  - Else decrement `cnt`.
- GATED:
  - If `wake_i | force_en_i`, go to WAKE and load `cnt = WAKE_LAT-1`.
  - `sleep_req_i` and `busy_i` are ignored here; they are frozen because the core clock is stopped.
- WAKE:
  - If `cnt == 0`, go to RUN and assert `wake_ack_o` for exactly one cycle.
  - Else decrement `cnt`.
  - `wake_i` deasserting during WAKE does not abort the wake.
- `clock_en_o` is a dedicated flop loaded with the next-state decode: 0 when the next state is GATED, otherwise 1. It is never a combinational decode, so it cannot glitch into the clock gate's enable latch.
- `sleeping_o` is a dedicated flop equal to (state == GATED).
- `wake_ack_o` is a flop, set on the WAKE→RUN transition edge.
- `gated_cnt_o` update rules:
  - Increments on each edge where state == GATED.
  - Saturates at all-ones.
  - `cnt_clr_i` wins over increment: clear to 0 on that edge.
- Reset (asynchronous, `rst_ni` = 0) sets:
  - state = RUN, `cnt` = 0
  - `clock_en_o` = 1, `sleeping_o` = 0, `wake_ack_o` = 0
  - `gated_cnt_o` = 0
- Reset asserted in any state, including GATED, immediately re-enables the clock (`clock_en_o` = 1). No wake ack is generated.

## Timing
- `idle` first sampled high at edge e (state RUN):
  - State is HOLDOFF after e.
  - If `idle` holds through edge e+HOLDOFF, state is GATED after e+HOLDOFF.
  - From that edge, `clock_en_o` = 0 and `sleeping_o` = 1.
  - Minimum gating latency is HOLDOFF+1 edges of `idle` high.
- `idle` dropping at any HOLDOFF edge returns the block to RUN on that edge. `clock_en_o` never drops.
- `wake_i` sampled high at edge w in GATED:
  - `clock_en_o` = 1 and `sleeping_o` = 0 after w.
  - State is RUN after w+WAKE_LAT.
  - `wake_ack_o` is high for the single cycle between edges w+WAKE_LAT and w+WAKE_LAT+1.
- `gated_cnt_o` value: the first GATED cycle is counted at the edge leaving that cycle, so the output lags state by one edge.
- `wake_i` and `idle` high together in RUN: `idle` is false by definition, so the block stays in RUN.
- `force_en_i` high in HOLDOFF aborts to RUN. High in GATED it behaves like `wake_i`.
- Back-to-back sleep: the block may re-enter HOLDOFF on the first RUN edge after `wake_ack_o`, provided `idle` is high.

## Test plan
- Reset, then `sleep_req_i` = 1 with `busy_i` = 0 held (HOLDOFF = 4): `clock_en_o` = 1 through edge 3, 0 after edge 4; `sleeping_o` = 1; `gated_cnt_o` = 3 after three GATED edges.
- Holdoff abort: `idle` high at edges 0–2, `busy_i` = 1 at edge 3 → state RUN, `clock_en_o` stays 1 throughout, no gating; repeat the abort using `wake_i` and using `force_en_i`.
- Wake (WAKE_LAT = 2): in GATED, pulse `wake_i` for 1 cycle at edge w → `clock_en_o` = 1 after w; `wake_ack_o` high exactly one cycle after w+2; no second ack.
- Counter: hold GATED for 10 cycles with `cnt_clr_i` pulsed on the 6th edge → `gated_cnt_o` = 0 then counts to 4; with `CNT_W` = 3, 12 GATED cycles → saturates at 7.
- Async reset: assert `rst_ni` = 0 mid-GATED, between clock edges → `clock_en_o` = 1 and `sleeping_o` = 0 immediately; after release, the block is in RUN and `wake_ack_o` never pulses.
- Back-to-back: after `wake_ack_o`, keep `sleep_req_i` = 1 → re-gates HOLDOFF+1 edges later; 100-cycle random `sleep_req_i`/`busy_i`/`wake_i` run checking no glitch-width `clock_en_o` changes against a reference model.
